sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Serial-in/parallel-out receiver: the receiving end of the serial stream produced by the team's N-bit shift register. It collects N serial bits, MSB-first or LSB-first, into a word. The word is presented on a valid/ready output buffer, so the next word can be received while the current one waits to be consumed. It sits between a serial link and a parallel consumer, and reports overrun when the consumer stalls.

Parameters:
N, 8, word width in bits (N >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled on this edge when high
dir  input  1  1 = MSB-first, 0 = LSB-first; sampled with bit 0 of each word
frame_sync  input  1  discard the partial word and restart at bit 0
dout  output  N  assembled word (registered)
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
overrun  output  1  sticky: a completed word was dropped
ovr_clr  input  1  clears overrun
busy  output  1  partial word in progress (bit count != 0)
parity_err  output  1  see Optional Feature

Behaviour:
- Reset (rst=1 on an edge): shift register=0, bit_cnt=0, state=IDLE, dout=0, dout_valid=0, overrun=0, busy=0, parity_err=0. Reset dominates all other inputs. A reset mid-word discards the partial word.
- FSM states:
  - IDLE: bit_cnt=0.
  - RECV: 0 < bit_cnt < N.
  - PAR: only with the Optional Feature.
- IDLE -> RECV on sin_valid. That bit is bit 0, and dir is latched into dir_q for the rest of the word.
- Shift rule:
  - dir_q=1: sreg <= {sreg[N-2:0], sin}.
  - dir_q=0: sreg <= {sin, sreg[N-1:1]}.
- Bit count: increments only on sin_valid. Gaps of any length are allowed and hold all state.
- Word completion: on the edge that samples bit N-1, the complete word (including that bit) is written to dout, and the FSM returns to IDLE.
  - Latency: dout_valid is high in the cycle after that edge.
  - Back-to-back words need no idle cycle.
- Output handshake:
  - dout_valid falls on the edge where dout_valid && dout_ready, unless a new word completes on that same edge. In that case dout is loaded with the new word and dout_valid stays 1.
  - Completion while dout_valid=1 and dout_ready=0: the new word is dropped, dout is unchanged, and overrun is set on that edge.
- overrun:
  - Cleared by ovr_clr.
  - If set and clear occur on the same edge, set wins.
- frame_sync:
  - bit_cnt -> 0, FSM -> IDLE, partial word discarded. The output buffer is unaffected.
  - If sin_valid is also high on that edge, sin becomes bit 0 of the new word, and dir is latched.
  - frame_sync on the completing edge cancels the completion.
- busy = (state != IDLE), registered.
- dir changes mid-word are ignored until the next bit 0.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- When defined:
  - Each word is N+1 bits. After bit N-1 the FSM enters PAR, and the next valid bit is the even-parity bit.
  - Completion (dout load, handshake, overrun) happens on the PAR edge.
  - parity_err is registered alongside dout and is 1 if ^{word,parity} != 0. It follows the same valid/ready rules as dout.
  - frame_sync in PAR discards the word.
- When undefined: PAR does not exist, frames are N bits, and parity_err is tied to 0.

Decomposition:
- Package sipo_pkg:
  - state enum {IDLE, RECV, PAR}.
  - DIR_MSB_FIRST=1'b1 and DIR_LSB_FIRST=1'b0.
  - Bit-count width function clog2(N+1).
- Sub-module sipo_out_buffer: the N-bit (+parity_err) holding register. It implements the valid/ready handshake and overrun detection, and is reusable by other serial receivers.

Test Plan (N=8, macro off unless stated):
- MSB-first: dir=1; sin = 0,0,0,0,0,0,1,1 with continuous sin_valid; dout_ready=1 -> dout=8'h03, dout_valid high one cycle after the 8th bit's edge.
- LSB-first: dir=0; same bit sequence -> dout=8'hC0. Toggling dir after bit 0 has no effect.
- Gapped input plus back-to-back words: sin_valid low for 3 cycles between bits, then two words 8'hA5 and 8'h3C sent with no gap -> both delivered in order, with no overrun.
- Backpressure:
  - Hold dout_ready=0 and send 8'h11 then 8'h22 -> dout stays 8'h11 and overrun=1.
  - Then ready=1 -> dout_valid falls.
  - ovr_clr -> overrun=0.
- frame_sync: assert after 5 bits, then send 8'h81 -> dout=8'h81 and busy=0 afterward.
- Reset after 4 bits -> all outputs 0; a following full word 8'hF0 is received correctly.
- With SIPO_PARITY_CHECK_EN: 8'h03 with parity bit 0 -> parity_err=0. Same word with parity bit 1 -> parity_err=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
// Optional feature macro used by the receiver: SIPO_PARITY_CHECK_EN.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PAR
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

    // Bit counter must be able to hold N (parity phase reaches it).
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// One-entry valid/ready holding register for received words, with sticky overrun.
// Reusable by any serial receiver that produces a word plus a parity-error flag.
module sipo_out_buffer
    import sipo_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         perr_i,
    input  logic         ready_i,
    input  logic         ovr_clr_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         perr_o,
    output logic         overrun_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         perr_q, perr_d;
    logic         ovr_q, ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
        if (load_i) begin
            // A consumed slot can be refilled on the same edge.
            if (!valid_q || ready_i) begin
                data_d  = data_i;
                perr_d  = perr_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver, MSB- or LSB-first, feeding a valid/ready output buffer.
// Define SIPO_PARITY_CHECK_EN to expect a trailing even-parity bit per word.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         dir,
    input  logic         frame_sync,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         overrun,
    input  logic         ovr_clr,
    output logic         busy,
    output logic         parity_err
);

    localparam int unsigned CntW = cnt_width(N);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    sreg_q, sreg_d;
    logic            dir_q, dir_d;
    logic            busy_q, busy_d;
    logic            word_done;
    logic            word_perr;

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] s, input logic b,
                                              input logic d);
        return (d == DIR_MSB_FIRST) ? {s[N-2:0], b} : {b, s[N-1:1]};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        word_perr = 1'b0;
        if (frame_sync) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (sin_valid) begin
                state_d = RECV;
                cnt_d   = CntW'(1);
                dir_d   = dir;
                sreg_d  = shift_in('0, sin, dir);
            end
        end else if (sin_valid) begin
            unique case (state_q)
                IDLE: begin
                    state_d = RECV;
                    cnt_d   = CntW'(1);
                    dir_d   = dir;
                    sreg_d  = shift_in('0, sin, dir);
                end
                RECV: begin
                    sreg_d = shift_in(sreg_q, sin, dir_q);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CntW'(N - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
                        state_d = PAR;
`else
                        state_d   = IDLE;
                        cnt_d     = '0;
                        word_done = 1'b1;
`endif
                    end
                end
                PAR: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    word_done = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
                    word_perr = ^{sreg_q, sin};
`endif
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            dir_q   <= DIR_MSB_FIRST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    // sreg_d already holds the full word on the completing edge.
    sipo_out_buffer #(
        .W(N)
    ) u_out_buffer (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (word_done),
        .data_i   (sreg_d),
        .perr_i   (word_perr),
        .ready_i  (dout_ready),
        .ovr_clr_i(ovr_clr),
        .data_o   (dout),
        .valid_o  (dout_valid),
        .perr_o   (parity_err),
        .overrun_o(overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed vectors, corner sequences and
// randomized traffic against a word-level reference model.
module tb_sipo_deserializer;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0, sin = 1'b0, sin_valid = 1'b0, dir = 1'b0, frame_sync = 1'b0;
    logic         dout_ready = 1'b0, ovr_clr = 1'b0;
    logic [N-1:0] dout;
    logic         dout_valid, overrun, busy, parity_err;

    always #5 clk = ~clk;

    sipo_deserializer #(
        .N(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .dir       (dir),
        .frame_sync(frame_sync),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .busy      (busy),
        .parity_err(parity_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: bits collected so far and the output slot.
    int           m_cnt = 0;
    bit           m_par = 1'b0;
    logic         m_dir = 1'b1;
    logic [N-1:0] m_word = '0;
    logic [N-1:0] m_dout = '0;
    logic         m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

    typedef struct {
        logic         dir;
        logic [N-1:0] seq;   // seq[N-1] is sent first
        logic [N-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_bit(input logic s);
        if (m_dir) m_word = N'(32'(m_word) * 2 + 32'(s));
        else m_word[m_cnt] = s;
        m_cnt++;
    endtask

    task automatic model_update(input logic r, v, s, d, f, rdy, oc);
        logic         done;
        logic [N-1:0] nw;
        logic         np;
        done = 1'b0;
        nw   = '0;
        np   = 1'b0;
        if (r) begin
            m_cnt = 0; m_par = 0; m_word = '0; m_dout = '0;
            m_valid = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        if (f || (v && m_cnt == 0 && !m_par)) begin
            m_cnt = 0;
            m_par = 0;
            if (v) begin
                m_dir  = d;
                m_word = '0;
                add_bit(s);
            end
        end else if (v) begin
            if (m_par) begin
                done = 1; nw = m_word; np = (^m_word) ^ s;
                m_par = 0; m_cnt = 0;
            end else begin
                add_bit(s);
                if (m_cnt == N) begin
                    m_cnt = 0;
`ifdef SIPO_PARITY_CHECK_EN
                    m_par = 1;
`else
                    done = 1; nw = m_word;
`endif
                end
            end
        end
        if (oc) m_ovr = 0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_dout = nw; m_perr = np; m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic r, v, s, d, f, rdy, oc);
        rst = r; sin_valid = v; sin = s; dir = d; frame_sync = f;
        dout_ready = rdy; ovr_clr = oc;
        @(posedge clk);
        model_update(r, v, s, d, f, rdy, oc);
        #1;
        check("model_dout", 32'(dout), 32'(m_dout));
        check("model_valid", 32'(dout_valid), 32'(m_valid));
        check("model_overrun", 32'(overrun), 32'(m_ovr));
        check("model_busy", 32'(busy), 32'((m_cnt != 0) || m_par));
        check("model_perr", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic send_word(input logic d, input logic [N-1:0] seq, input logic par,
                             input int gap, input logic rdy);
        for (int k = 0; k < int'(N); k++) begin
            if (k != 0) repeat (gap) step(0, 0, 0, d, 0, rdy, 0);
            step(0, 1, seq[N-1-k], (k == 0) ? d : ~d, 0, rdy, 0);
        end
`ifdef SIPO_PARITY_CHECK_EN
        step(0, 1, par, d, 0, rdy, 0);
`else
        if (par) begin end
`endif
    endtask

    initial begin
        vecs[0] = '{dir: 1'b1, seq: 8'h03, exp: 8'h03};
        vecs[1] = '{dir: 1'b0, seq: 8'h03, exp: 8'hC0};
        vecs[2] = '{dir: 1'b1, seq: 8'hA5, exp: 8'hA5};
        vecs[3] = '{dir: 1'b0, seq: 8'h01, exp: 8'h80};
        vecs[4] = '{dir: 1'b0, seq: 8'hF0, exp: 8'h0F};
        vecs[5] = '{dir: 1'b1, seq: 8'h3C, exp: 8'h3C};

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1);
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_perr", 32'(parity_err), 0);

        // Table: dir toggled after bit 0 must be ignored.
        foreach (vecs[i]) begin
            for (int k = 0; k < int'(N); k++) begin
                step(0, 1, vecs[i].seq[N-1-k], (k == 0) ? vecs[i].dir : ~vecs[i].dir, 0, 1, 0);
                if (k == int'(N) - 2) check("vec_not_early", 32'(dout_valid), 0);
            end
`ifdef SIPO_PARITY_CHECK_EN
            step(0, 1, ^vecs[i].seq, 0, 0, 1, 0);
`endif
            check("vec_dout", 32'(dout), 32'(vecs[i].exp));
            check("vec_valid", 32'(dout_valid), 1);
            check("vec_perr", 32'(parity_err), 0);
            step(0, 0, 0, 0, 0, 1, 0);
            check("vec_consumed", 32'(dout_valid), 0);
        end

        // Gapped word, then two back-to-back words.
        send_word(1, 8'hA5, ^8'hA5, 3, 1);
        check("gap_dout", 32'(dout), 32'hA5);
        send_word(1, 8'hA5, ^8'hA5, 0, 1);
        check("b2b_first", 32'(dout), 32'hA5);
        send_word(1, 8'h3C, ^8'h3C, 0, 1);
        check("b2b_second", 32'(dout), 32'h3C);
        check("b2b_valid", 32'(dout_valid), 1);
        check("b2b_no_ovr", 32'(overrun), 0);

        // Backpressure and overrun.
        step(0, 0, 0, 0, 0, 1, 0);
        send_word(1, 8'h11, ^8'h11, 0, 0);
        check("bp_first", 32'(dout), 32'h11);
        check("bp_first_ovr", 32'(overrun), 0);
        send_word(1, 8'h22, ^8'h22, 0, 0);
        check("bp_hold", 32'(dout), 32'h11);
        check("bp_ovr", 32'(overrun), 1);
        step(0, 0, 0, 0, 0, 1, 0);
        check("bp_drain", 32'(dout_valid), 0);
        check("bp_ovr_sticky", 32'(overrun), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("bp_ovr_clr", 32'(overrun), 0);

        // frame_sync after 5 bits restarts with the new word's bit 0.
        for (int k = 0; k < 5; k++) step(0, 1, 1, 1, 0, 1, 0);
        for (int k = 0; k < int'(N); k++) begin
            logic [N-1:0] w;
            w = 8'h81;
            step(0, 1, w[N-1-k], 1, (k == 0), 1, 0);
        end
`ifdef SIPO_PARITY_CHECK_EN
        step(0, 1, 0, 1, 0, 1, 0);
`endif
        check("fs_dout", 32'(dout), 32'h81);
        step(0, 0, 0, 0, 0, 1, 0);
        check("fs_busy", 32'(busy), 0);

        // Reset mid-word, then a full word.
        for (int k = 0; k < 4; k++) step(0, 1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0);
        check("rst_mid_dout", 32'(dout), 0);
        check("rst_mid_valid", 32'(dout_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        send_word(1, 8'hF0, ^8'hF0, 0, 1);
        check("after_rst_dout", 32'(dout), 32'hF0);

`ifdef SIPO_PARITY_CHECK_EN
        send_word(1, 8'h03, 1'b0, 0, 1);
        check("par_good", 32'(parity_err), 0);
        send_word(1, 8'h03, 1'b1, 0, 1);
        check("par_bad", 32'(parity_err), 1);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(199) == 0, $urandom_range(99) < 70, 1'($urandom),
                 1'($urandom), $urandom_range(99) < 3, $urandom_range(99) < 60,
                 $urandom_range(99) < 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
